// File: rtl/vmi_pkg.sv
// Shared widths and operand/product types for the registered signed multiplier.
package vmi_pkg;

  localparam int VMI_WIDTH  = 32;
  localparam int VMI_PROD_W = 2 * VMI_WIDTH;

  typedef logic signed [VMI_WIDTH-1:0]  operand_t;
  typedef logic signed [VMI_PROD_W-1:0] product_t;

endpackage

// File: rtl/verilog_multiplier_integrated_signed_mult_core.sv
// Combinational radix-4 Booth multiplier: WIDTH/2 partial products summed by a binary adder tree.
module signed_mult_core #(
  parameter int WIDTH = vmi_pkg::VMI_WIDTH
) (
  input  logic signed [WIDTH-1:0]   x,
  input  logic signed [WIDTH-1:0]   y,
  output logic signed [2*WIDTH-1:0] p
);

  localparam int NPP = WIDTH / 2;

  // Booth digit for one 3-bit window of the multiplier: 0, +-x or +-2x.
  function automatic logic signed [2*WIDTH-1:0] booth_pp(
    input logic signed [2*WIDTH-1:0] xe,
    input logic [2:0]                code
  );
    logic signed [2*WIDTH-1:0] r;
    r = '0;
    case (code)
      3'b001, 3'b010: r = xe;
      3'b011:         r = xe <<< 1;
      3'b100:         r = -(xe <<< 1);
      3'b101, 3'b110: r = -xe;
      default:        r = '0;
    endcase
    return r;
  endfunction

  logic signed [2*WIDTH-1:0] xe;
  logic        [WIDTH:0]     yz;
  // Heap-ordered tree: leaves at NPP-1..2*NPP-2, node i sums children 2i+1 and 2i+2.
  logic signed [2*WIDTH-1:0] node [2*NPP-1];

  assign xe = {{WIDTH{x[WIDTH-1]}}, x};
  assign yz = {y, 1'b0};

  for (genvar j = 0; j < NPP; j++) begin : g_pp
    assign node[NPP-1+j] = booth_pp(xe, yz[2*j +: 3]) <<< (2*j);
  end

  for (genvar i = 0; i < NPP-1; i++) begin : g_tree
    assign node[i] = node[2*i+1] + node[2*i+2];
  end

  assign p = node[0];

endmodule

// File: rtl/verilog_multiplier_integrated.sv
// Registered signed multiplier: operand registers A/B, Booth core, product register.
// Define VMI_PIPELINE_EN to add a free-running register on the core output (3-cycle latency).
module verilog_multiplier_integrated
  import vmi_pkg::*;
#(
  parameter int WIDTH = VMI_WIDTH
) (
  input  logic                     clk,
  input  logic                     resetA,
  input  logic                     resetB,
  input  logic                     resetOut,
  input  logic signed [WIDTH-1:0]  a,
  input  logic signed [WIDTH-1:0]  b,
  input  logic                     enableA,
  input  logic                     enableB,
  input  logic                     enableOut,
  output logic signed [2*WIDTH-1:0] product
);

  // No handshake: the host sequences loads and the product strobe itself.
  logic signed [WIDTH-1:0]   rega;
  logic signed [WIDTH-1:0]   regb;
  logic signed [2*WIDTH-1:0] mul_c;
  logic signed [2*WIDTH-1:0] mul_sel;

  always_ff @(posedge clk) begin
    if (resetA)       rega <= '0;
    else if (enableA) rega <= a;
  end

  always_ff @(posedge clk) begin
    if (resetB)       regb <= '0;
    else if (enableB) regb <= b;
  end

  signed_mult_core #(.WIDTH(WIDTH)) u_core (
    .x (rega),
    .y (regb),
    .p (mul_c)
  );

`ifdef VMI_PIPELINE_EN
  logic signed [2*WIDTH-1:0] mul_q;

  always_ff @(posedge clk) begin
    if (resetOut) mul_q <= '0;
    else          mul_q <= mul_c;
  end

  assign mul_sel = mul_q;
`else
  assign mul_sel = mul_c;
`endif

  always_ff @(posedge clk) begin
    if (resetOut)       product <= '0;
    else if (enableOut) product <= mul_sel;
  end

endmodule

// File: tb/tb_verilog_multiplier_integrated.sv
// Bench for verilog_multiplier_integrated: directed spec cases plus random traffic vs. an arithmetic model.
module tb_verilog_multiplier_integrated;
  import vmi_pkg::*;

`ifdef VMI_PIPELINE_EN
  localparam bit PIPE = 1'b1;
  localparam int LAT  = 3;
`else
  localparam bit PIPE = 1'b0;
  localparam int LAT  = 2;
`endif

  // clock / reset block
  logic     clk = 1'b0;
  logic     resetA, resetB, resetOut;
  logic     enableA, enableB, enableOut;
  operand_t a, b;
  product_t product;

  always #5 clk = ~clk;

  verilog_multiplier_integrated dut (
    .clk       (clk),
    .resetA    (resetA),
    .resetB    (resetB),
    .resetOut  (resetOut),
    .a         (a),
    .b         (b),
    .enableA   (enableA),
    .enableB   (enableB),
    .enableOut (enableOut),
    .product   (product)
  );

  // reference model state: what each architectural register should hold
  operand_t rega_m = '0, regb_m = '0;
  product_t pipe_m = '0, prod_m = '0;
  int       vectors = 0;
  int       miscompares = 0;

  function automatic product_t mul(input operand_t x, input operand_t y);
    product_t xe, ye;
    xe = product_t'(x);
    ye = product_t'(y);
    return xe * ye;
  endfunction

  task automatic check(input string tag, input product_t obs, input product_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of controls, advance the model, compare after the edge
  task automatic step(input logic ra, input logic rb, input logic ro,
                      input logic ea, input logic eb, input logic eo,
                      input operand_t av, input operand_t bv, input string tag);
    product_t full, prod_n, pipe_n;
    resetA = ra; resetB = rb; resetOut = ro;
    enableA = ea; enableB = eb; enableOut = eo;
    a = av; b = bv;
    @(posedge clk);
    full   = mul(rega_m, regb_m);
    pipe_n = ro ? '0 : full;
    prod_n = ro ? '0 : (eo ? (PIPE ? pipe_m : full) : prod_m);
    pipe_m = pipe_n;
    prod_m = prod_n;
    rega_m = ra ? '0 : (ea ? av : rega_m);
    regb_m = rb ? '0 : (eb ? bv : regb_m);
    #1;
    check(tag, product, prod_m);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, a, b, tag);
  endtask

  // load both operands, wait out the latency, strobe the product, compare to a constant
  task automatic run_case(input operand_t av, input operand_t bv,
                          input product_t exp, input string tag);
    step(0, 0, 0, 1, 1, 0, av, bv, {tag, "_load"});
    repeat (LAT - 2) idle({tag, "_wait"});
    step(0, 0, 0, 0, 0, 1, av, bv, {tag, "_cap"});
    check(tag, product, exp);
  endtask

  function automatic operand_t pick();
    case ($urandom_range(0, 7))
      0:       return 32'sh8000_0000;
      1:       return 32'sh7FFF_FFFF;
      2:       return -32'sd1;
      3:       return 32'sd0;
      4:       return 32'sd1;
      default: return operand_t'($urandom());
    endcase
  endfunction

  initial begin
    resetA = 1; resetB = 1; resetOut = 1;
    enableA = 0; enableB = 0; enableOut = 0;
    a = '0; b = '0;
    @(posedge clk);
    #1;
    // first fully-defined state comes from this reset edge
    step(1, 1, 1, 0, 0, 0, 32'sd0, 32'sd0, "reset");
    check("reset_const", product, 64'sd0);

    run_case(32'sd5,   32'sd6,   64'sd30,  "pos_pos");
    run_case(-32'sd4,  -32'sd7,  64'sd28,  "neg_neg");
    run_case(32'sd10,  -32'sd4,  64'shFFFF_FFFF_FFFF_FFD8, "pos_neg");
    run_case(-32'sd50, 32'sd5,   -64'sd250, "neg_pos");
    run_case(32'sd1234, 32'sd0,  64'sd0,   "zero_b");
    run_case(32'sd0,   32'sd0,   64'sd0,   "zero_zero");
    run_case(32'sd99,  32'sd1,   64'sd99,  "identity");
    run_case(32'sd32,  32'sd23,  64'sd736, "small");
    run_case(32'sh8000_0000, 32'sh8000_0000, 64'sh4000_0000_0000_0000, "min_min");
    run_case(32'sh7FFF_FFFF, -32'sd1, -64'sd2147483647, "max_neg1");

    // hold: a changes with enableA low; recapture must repeat the old product
    run_case(32'sd5, 32'sd6, 64'sd30, "hold_setup");
    step(0, 0, 0, 0, 0, 0, 32'sd77, 32'sd88, "hold_idle");
    check("hold_noen", product, 64'sd30);
    repeat (LAT - 1) idle("hold_wait");
    step(0, 0, 0, 0, 0, 1, 32'sd77, 32'sd88, "hold_cap");
    check("hold_recap", product, 64'sd30);

    // reset beats enable on regA
    step(1, 0, 0, 1, 0, 0, 32'sd55, 32'sd0, "rsta_ena");
    repeat (LAT - 2) idle("rsta_wait");
    step(0, 0, 0, 0, 0, 1, 32'sd0, 32'sd0, "rsta_cap");
    check("rsta_priority", product, 64'sd0);

    // resetOut clears only the product; a later strobe recaptures from kept operands
    run_case(32'sd5, 32'sd6, 64'sd30, "ro_setup");
    step(0, 0, 1, 0, 0, 0, 32'sd0, 32'sd0, "ro_clear");
    check("ro_zero", product, 64'sd0);
    repeat (LAT - 1) idle("ro_wait");
    step(0, 0, 0, 0, 0, 1, 32'sd0, 32'sd0, "ro_recap");
    check("ro_recap_val", product, 64'sd30);

    // same edge: new a loaded while capturing -> product from old regA
    idle("same_settle");
    step(0, 0, 0, 1, 0, 1, 32'sd7, 32'sd0, "same_edge");
    check("same_edge_old", product, 64'sd30);
    repeat (LAT - 1) idle("same_wait");
    step(0, 0, 0, 0, 0, 1, 32'sd0, 32'sd0, "same_new");
    check("same_edge_new", product, 64'sd42);

    // same edge: resetA with capture -> pre-reset product
    step(1, 0, 0, 0, 0, 1, 32'sd0, 32'sd0, "rsta_same");
    check("rsta_same_old", product, 64'sd42);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, pick(), pick(), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
